// File: rtl/ex_resolve_stage.sv
// Execute-resolve stage: decodes write/memory/branch outcome of each ALU result,
// tracks the architectural carry and buffers resolved entries in a small FIFO.
module ex_resolve_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic [2:0]  in_flags,
    input  logic [4:0]  in_control,
    input  logic [1:0]  in_br_type,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_offset,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic [1:0]  out_mem,
    output logic        out_br_taken,
    output logic [31:0] out_br_target,
    output logic        carry_q
);

    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam int ENT_W = 32 + 5 + 1 + 2 + 1 + 32;
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic             rdy_q;
    logic [ENT_W-1:0] buf_q [DEPTH];

    logic             push, pop;
    logic             we_d, taken_d, carry_d;
    logic [1:0]       mem_d;
    logic [31:0]      target_d;
    logic [ENT_W-1:0] entry_d, head;

    // rdy_q holds in_ready low until the first edge after reset release
    assign in_ready  = rdy_q & (count_q < FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        we_d    = 1'b0;
        mem_d   = 2'd0;
        taken_d = 1'b0;
        carry_d = carry_q;
        if ((in_control >= 5'd1 && in_control <= 5'd10) ||
            (in_control >= 5'd16 && in_control <= 5'd18)) begin
            we_d = (in_rd != 5'd0);
        end
        case (in_control)
            5'd0: begin
                case (in_br_type)
                    2'd0:    taken_d = 1'b1;
                    2'd1:    taken_d = carry_q;
                    2'd2:    taken_d = ~carry_q;
                    default: taken_d = 1'b0;
                endcase
            end
            5'd11: taken_d = in_flags[2];
            5'd12: taken_d = in_flags[0];
            5'd13: taken_d = ~in_flags[0];
            5'd14: mem_d = 2'd1;
            5'd15: mem_d = 2'd2;
            5'd1, 5'd9: carry_d = in_flags[1];
            5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd10,
            5'd16, 5'd17, 5'd18: carry_d = 1'b0;
            default: ;
        endcase
        target_d = taken_d ? (in_pc + in_offset) : 32'd0;
        entry_d  = {in_result, in_rd, we_d, mem_d, taken_d, target_d};
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdy_q    <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            rdy_q   <= 1'b1;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                carry_q  <= carry_d;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr_q] <= entry_d;
        end
    end

    // Outputs are forced to zero whenever the head is empty, including under reset
    assign head = out_valid ? buf_q[rd_ptr_q] : '0;
    assign {out_result, out_rd, out_we, out_mem, out_br_taken, out_br_target} = head;

endmodule
